// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - Round-robin arbiter driving the select pair of a 4:1 mux stage
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] grant_o,
    output logic       valid_o,
    output logic       select1_o,
    output logic       select2_o,
    output logic       preempt_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit                 PREEMPT_EN = (MAX_HOLD != 0);
    localparam int unsigned        HOLD_LAST  = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(HOLD_LAST);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [1:0]       sel_q, sel_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       rel_done, rel_drop, rel_hold, others_req;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        others_req = |(req_i & ~grant_q);
        rel_done   = done_i;
        rel_drop   = !req_i[sel_q];
        rel_hold   = PREEMPT_EN && (cnt_q == CNT_LAST) && others_req;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        sel_d     = sel_q;
        preempt_d = 1'b0;
        cnt_d     = cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    sel_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // Release always lands in IDLE, which provides the guard gap.
                if (rel_done || rel_drop || rel_hold) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    valid_d   = 1'b0;
                    last_d    = sel_q;
                    preempt_d = rel_hold && !rel_done && !rel_drop;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            sel_q     <= 2'b00;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 2'd3;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
        end
    end

    assign grant_o   = grant_q;
    assign valid_o   = valid_q;
    assign select1_o = sel_q[0];
    assign select2_o = sel_q[1];
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - Directed self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

    logic       clk_i;
    logic       rst_n_i;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] grant_o;
    logic       valid_o;
    logic       select1_o;
    logic       select2_o;
    logic       preempt_o;

    int n_cmp;
    int n_err;

    // {preempt, valid, s2, s1, grant}
    logic [7:0] obs;
    assign obs = {preempt_o, valid_o, select2_o, select1_o, grant_o};

    mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (req_i),
        .done_i    (done_i),
        .grant_o   (grant_o),
        .valid_o   (valid_o),
        .select1_o (select1_o),
        .select2_o (select2_o),
        .preempt_o (preempt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        req_i   = 4'b0000;
        done_i  = 1'b0;
        #2;
        rst_n_i = 1'b1;
    endtask

    function automatic logic [7:0] granted(input logic [1:0] idx);
        logic [3:0] g;
        g = 4'b0001 << idx;
        return {1'b0, 1'b1, idx, g};
    endfunction

    function automatic logic [7:0] gap(input logic [1:0] idx, input logic pre);
        return {pre, 1'b0, idx, 4'b0000};
    endfunction

    logic [1:0] rr_seq [5];

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n_i = 1'b0;
        req_i   = 4'b0000;
        done_i  = 1'b0;
        rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // 1: reset state, single request, done release
        @(negedge clk_i);
        check_eq("reset_state", obs, 8'h00);
        rst_n_i = 1'b1;
        req_i   = 4'b0001;
        step();
        check_eq("t1_grant_a", obs, granted(2'd0));
        done_i = 1'b1;
        step();
        check_eq("t1_release", obs, gap(2'd0, 1'b0));
        done_i = 1'b0;
        req_i  = 4'b0000;
        done_i = 1'b1;
        step();
        check_eq("t1_idle_done_ignored", obs, gap(2'd0, 1'b0));
        done_i = 1'b0;

        // 2: full round robin with done pulses, pointer restored by reset
        do_reset();
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("t2_grant%0d", i), obs, granted(rr_seq[i]));
            step();
            check_eq($sformatf("t2_hold%0d", i), obs, granted(rr_seq[i]));
            done_i = 1'b1;
            step();
            check_eq($sformatf("t2_gap%0d", i), obs, gap(rr_seq[i], 1'b0));
            done_i = 1'b0;
        end

        // 3: max-hold preemption A -> B
        do_reset();
        req_i = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("t3_hold_a%0d", i), obs, granted(2'd0));
        end
        step();
        check_eq("t3_preempt", obs, gap(2'd0, 1'b1));
        step();
        check_eq("t3_grant_b", obs, granted(2'd1));

        // 3b: done on the expiry edge suppresses the preempt pulse
        do_reset();
        req_i = 4'b0011;
        for (int i = 0; i < 8; i++) step();
        check_eq("t3b_still_a", obs, granted(2'd0));
        done_i = 1'b1;
        step();
        check_eq("t3b_no_preempt", obs, gap(2'd0, 1'b0));
        done_i = 1'b0;

        // 4: lone requester holds past MAX_HOLD and counter saturation
        do_reset();
        req_i = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i % 5 == 0 || i == 19)
                check_eq($sformatf("t4_hold_c%0d", i), obs, granted(2'd2));
        end

        // 5: D releases with req drop + done while A rises; wrap to A
        do_reset();
        req_i = 4'b1000;
        step();
        check_eq("t5_grant_d", obs, granted(2'd3));
        req_i  = 4'b0001;
        done_i = 1'b1;
        step();
        check_eq("t5_release", obs, gap(2'd3, 1'b0));
        done_i = 1'b0;
        step();
        check_eq("t5_grant_a", obs, granted(2'd0));

        // 6: asynchronous reset between edges, then regrant B
        do_reset();
        req_i = 4'b0010;
        step();
        check_eq("t6_grant_b", obs, granted(2'd1));
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("t6_async_clear", obs, 8'h00);
        rst_n_i = 1'b1;
        step();
        check_eq("t6_regrant_b", obs, granted(2'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
